fft64_bitrev_reorder: RTL
=========================

Name: fft64_bitrev_reorder

Overview:
- Downstream neighbour of fft64_streaming: consumes its bit-reversed-order output stream and re-emits each 64-point frame in natural frequency order.
- Ping-pong (two-bank) frame buffer: one bank is written at bit-reversed addresses while the other is read sequentially.
- Supports continuous back-to-back frames with no output gaps within a frame.
- Feeds the spectral post-processing / capture logic.

Parameters:
- DATA_W, 20, width of each real/imag component; equals the FFT output width DATA_W+GROWTH.
- POINTS, 64, frame length; must be a power of two.
- ADDR_W, $clog2(POINTS), address/counter width (localparam).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- real_in  in  DATA_W  signed real part, in FFT output (bit-reversed) order.
- imag_in  in  DATA_W  signed imaginary part.
- valid_in  in  1  sample qualifier; gaps allowed.
- last_in  in  1  marks the 64th sample of a frame; qualified by valid_in.
- real_out  out  DATA_W  signed real part, natural order.
- imag_out  out  DATA_W  signed imaginary part.
- valid_out  out  1  output qualifier.
- last_out  out  1  high with output sample index POINTS-1.
- done  out  1  one-cycle pulse, coincident with last_out.
- frame_err  out  1  sticky flag: last_in misaligned, or a write arrived with no free bank.

Behaviour:
- Reset: asynchronous assert on rst_n low.
  - All outputs go to 0, write/read counters to 0, both banks FREE, write-bank pointer to bank 0.
  - Memory contents are not reset.
  - Reset mid-frame discards any partial or undrained data.
- Bank states: FREE -> FILLING (first accepted write) -> FULL (64th write) -> DRAINING (read starts) -> FREE (after read of index 63).
- Write side, each valid_in cycle:
  - Store {real_in, imag_in} at addr = bitrev(wr_cnt) in the current write bank; wr_cnt increments.
  - At wr_cnt == POINTS-1: mark the bank FULL, toggle the write-bank pointer, clear wr_cnt.
- last_in checks:
  - last_in with wr_cnt != POINTS-1: set frame_err, discard the partial frame (bank returns to FREE, wr_cnt = 0).
  - wr_cnt == POINTS-1 without last_in: the frame is still committed, and frame_err is set.
- Read side:
  - When the read bank is FULL and no drain is active, draining starts on the next edge.
  - Outputs are registered. Sample n = bank[n] appears on the edge following the read-address cycle.
  - Output n is always valid for 64 consecutive cycles, n = 0..63.
- Latency: output index 0 is valid on the 2nd rising edge after the edge that writes input 63. Every later frame's latency is identical.
- Back-to-back frames:
  - If the other bank becomes FULL while the current bank drains, its drain starts the cycle immediately after last_out.
  - No idle cycle between frames.
- Write into a bank that is not FREE: the write is dropped and frame_err is set. This cannot occur at a 1-sample/cycle source rate, but it must be handled.
- Simultaneous events: writing the last sample of bank A and reading the last sample of bank B in the same cycle is legal. B becomes FREE and A becomes FULL in the same edge.
- Arithmetic: pure data movement, no width change or rounding. Output values are bit-identical to the inputs.
- frame_err clears only on reset.

Decomposition:
- Shared package fft_pkg:
  - FFT_POINTS, FFT_OUT_W constants.
  - Bank-state enum {FREE, FILLING, FULL, DRAINING}.
  - bitrev function, parameterised by ADDR_W.
- One sub-module, fft_pingpong_ram: dual-bank 2*POINTS x (2*DATA_W) register array, one write port and one read port, bank-select bit as the address MSB.
- Control FSMs stay in the top.

Test Plan:
- Ordering: frame with input k carrying real=k, imag=-k (k = 0..63), last_in at k=63.
  - Outputs n = 0..63 have real=bitrev6(n), imag=-bitrev6(n).
  - e.g. n=1 -> 32, n=2 -> 16, n=63 -> 63.
  - last_out and done only at n=63; frame_err = 0.
- Latency: same frame.
  - First valid_out exactly 2 edges after the edge capturing input 63.
  - 64 contiguous valid_out cycles.
- Back-to-back: 3 frames streamed with no gaps, frame f carrying real = 100*f + k.
  - 192 contiguous valid_out cycles, each frame correctly reordered.
  - done pulses 3 times, 64 cycles apart.
- Gapped input: valid_in toggled 1,0,1,0 across a frame.
  - Output order is identical to the ordering test; output is contiguous after the frame completes.
- Misaligned last: last_in asserted on the 40th sample, then a clean 64-sample frame.
  - frame_err = 1 sticky; the 40-sample frame produces no output.
  - The following frame is output correctly.
- Reset mid-drain: rst_n low at output n=20 for 2 cycles.
  - valid_out, last_out and done drop to 0 immediately; no further output until a new full frame is written.
  - That new frame is correctly ordered.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT constants, bank-state encoding and the bit-reversal helper used
// by the natural-order reorder stage.
package fft_pkg;

   localparam int FFT_POINTS   = 64;
   localparam int FFT_OUT_W    = 20;

   // Widest address the bit-reversal helper supports.
   localparam int BITREV_MAX_W = 16;

   // Life cycle of one ping-pong bank.
   typedef enum logic [1:0] {
      BANK_FREE     = 2'd0,
      BANK_FILLING  = 2'd1,
      BANK_FULL     = 2'd2,
      BANK_DRAINING = 2'd3
   } bank_state_t;

   // Reverse the low addr_w bits of value; bits above addr_w come back as zero.
   // Reversing the full word moves bit 0 to the MSB, so shifting right by
   // (BITREV_MAX_W - addr_w) lands the reversed field at the bottom.
   function automatic logic [BITREV_MAX_W-1:0] bitrev(
      input logic [BITREV_MAX_W-1:0] value,
      input int unsigned             addr_w
   );
      logic [BITREV_MAX_W-1:0] rev;
      rev = {<<{value}};
      return rev >> (BITREV_MAX_W - addr_w);
   endfunction

endpackage

// File: rtl/fft64_bitrev_reorder_if.sv
// Sample bus between the FFT core, the reorder stage and the capture logic.
//
// Handshake: there is no backpressure. A sample (and its last flag) is
// transferred on every rising clock edge where the matching valid is high;
// last is ignored when valid is low. Gaps are allowed on the input side. The
// output side presents each frame as POINTS consecutive valid cycles.
interface fft64_bitrev_reorder_if #(
   parameter int DATA_W = fft_pkg::FFT_OUT_W
);

   logic signed [DATA_W-1:0] real_in;
   logic signed [DATA_W-1:0] imag_in;
   logic                     valid_in;
   logic                     last_in;

   logic signed [DATA_W-1:0] real_out;
   logic signed [DATA_W-1:0] imag_out;
   logic                     valid_out;
   logic                     last_out;
   logic                     done;
   logic                     frame_err;

   // Packed {bank1, bank0} state, two bits per bank.
   logic [3:0]               bank_dbg;

   // Source side and sink side of the block (the environment around it).
   modport master (
      output real_in, imag_in, valid_in, last_in,
      input  real_out, imag_out, valid_out, last_out, done, frame_err, bank_dbg
   );

   // The reorder block itself.
   modport slave (
      input  real_in, imag_in, valid_in, last_in,
      output real_out, imag_out, valid_out, last_out, done, frame_err, bank_dbg
   );

endinterface

// File: rtl/fft_pingpong_ram.sv
// Two-bank frame store: one synchronous write port, one asynchronous read
// port. The bank-select bit is the address MSB, so bank b occupies entries
// b*POINTS .. b*POINTS+POINTS-1. Contents are deliberately not reset.
module fft_pingpong_ram
   import fft_pkg::*;
#(
   parameter int DATA_W = FFT_OUT_W,
   parameter int POINTS = FFT_POINTS
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [$clog2(POINTS):0] waddr,
   input  logic [2*DATA_W-1:0]   wdata,
   input  logic [$clog2(POINTS):0] raddr,
   output logic [2*DATA_W-1:0]   rdata
);

   logic [2*DATA_W-1:0] mem [2*POINTS];

   // Write port: one {real, imag} word per accepted input sample.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read port is combinational; the top registers the result.
   assign rdata = mem[raddr];

endmodule

// File: rtl/fft64_bitrev_reorder.sv
// Reorders the bit-reversed output stream of the streaming FFT into natural
// frequency order. One bank is written at bit-reversed addresses while the
// other is read sequentially, so back-to-back frames stream without gaps.
module fft64_bitrev_reorder
   import fft_pkg::*;
#(
   parameter int DATA_W = FFT_OUT_W,
   parameter int POINTS = FFT_POINTS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   fft64_bitrev_reorder_if.slave bus
);

   localparam int                ADDR_W   = $clog2(POINTS);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(POINTS - 1);

   // Per-bank state and the write/read pointers.
   bank_state_t          bank_state [2];
   bank_state_t          bank_nxt   [2];
   logic                 wr_bank;
   logic [ADDR_W-1:0]    wr_cnt;
   logic                 rd_bank;
   logic [ADDR_W-1:0]    rd_cnt;
   logic                 drain_active;

   // Registered outputs.
   logic [DATA_W-1:0]    real_q;
   logic [DATA_W-1:0]    imag_q;
   logic                 valid_q;
   logic                 last_q;
   logic                 done_q;
   logic                 frame_err_q;

   // Write-side decode.
   logic                 rd_finishing;
   logic                 wr_bank_free;
   logic                 wr_ok;
   logic                 wr_accept;
   logic                 wr_drop;
   logic                 wr_at_last;
   logic                 last_early;
   logic                 last_missing;
   logic                 commit;

   // Read-side decode.
   logic                 drain_start;
   logic                 drain_chain;

   // Memory ports.
   logic                 ram_we;
   logic [ADDR_W:0]      ram_waddr;
   logic [ADDR_W:0]      ram_raddr;
   logic [2*DATA_W-1:0]  ram_wdata;
   logic [2*DATA_W-1:0]  ram_rdata;
   logic [BITREV_MAX_W-1:0] wr_rev;
   logic                 unused_rev_hi;

   // Accept/drop/error decode for the incoming sample.
   always_comb begin
      // The bank whose index 63 is read this cycle is free at the coming
      // edge, so a new frame may begin writing into it now: its first write
      // address is bitrev(0) = 0, which was read long ago.
      rd_finishing = drain_active && (rd_cnt == LAST_IDX);
      wr_bank_free = (bank_state[wr_bank] == BANK_FREE) ||
                     (rd_finishing && (rd_bank == wr_bank));
      wr_ok        = (wr_cnt == '0) ? wr_bank_free
                                    : (bank_state[wr_bank] == BANK_FILLING);
      wr_accept    = bus.valid_in && wr_ok;
      wr_drop      = bus.valid_in && !wr_ok;
      wr_at_last   = (wr_cnt == LAST_IDX);
      last_early   = wr_accept && bus.last_in && !wr_at_last;
      last_missing = wr_accept && wr_at_last && !bus.last_in;
      commit       = wr_accept && wr_at_last;
   end

   // Drain start from idle, and seamless hand-over to the other bank.
   always_comb begin
      drain_start = !drain_active && (bank_state[rd_bank] == BANK_FULL);
      drain_chain = rd_finishing && (bank_state[~rd_bank] == BANK_FULL);
   end

   // Next bank states: read-side transitions first, write side last, so a
   // bank that finishes draining and starts filling on one edge ends FILLING.
   always_comb begin
      bank_nxt[0] = bank_state[0];
      bank_nxt[1] = bank_state[1];
      if (drain_start) begin
         bank_nxt[rd_bank] = BANK_DRAINING;
      end
      if (rd_finishing) begin
         bank_nxt[rd_bank] = BANK_FREE;
         if (drain_chain) begin
            bank_nxt[~rd_bank] = BANK_DRAINING;
         end
      end
      if (wr_accept) begin
         if (last_early) begin
            bank_nxt[wr_bank] = BANK_FREE;
         end else if (commit) begin
            bank_nxt[wr_bank] = BANK_FULL;
         end else begin
            bank_nxt[wr_bank] = BANK_FILLING;
         end
      end
   end

   // Memory addressing: bit-reversed write address, sequential read address.
   always_comb begin
      wr_rev    = bitrev(BITREV_MAX_W'(wr_cnt), ADDR_W);
      ram_we    = wr_accept && !last_early;
      ram_waddr = {wr_bank, wr_rev[ADDR_W-1:0]};
      ram_wdata = {bus.real_in, bus.imag_in};
      ram_raddr = {rd_bank, rd_cnt};
   end

   assign unused_rev_hi = ^wr_rev[BITREV_MAX_W-1:ADDR_W];

   fft_pingpong_ram #(
      .DATA_W (DATA_W),
      .POINTS (POINTS)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   // Bank FSMs, write/read counters, error flag and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_state[0] <= BANK_FREE;
         bank_state[1] <= BANK_FREE;
         wr_bank       <= 1'b0;
         wr_cnt        <= '0;
         rd_bank       <= 1'b0;
         rd_cnt        <= '0;
         drain_active  <= 1'b0;
         real_q        <= '0;
         imag_q        <= '0;
         valid_q       <= 1'b0;
         last_q        <= 1'b0;
         done_q        <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         bank_state <= bank_nxt;

         // Write side: a misaligned last discards the partial frame, a
         // completed frame hands the write pointer to the other bank.
         if (wr_accept) begin
            if (last_early || wr_at_last) begin
               wr_cnt <= '0;
            end else begin
               wr_cnt <= wr_cnt + 1'b1;
            end
            if (commit) begin
               wr_bank <= ~wr_bank;
            end
         end

         if (wr_drop || last_early || last_missing) begin
            frame_err_q <= 1'b1;
         end

         // Read side: the address issued this cycle becomes the output word
         // on this edge.
         if (drain_active) begin
            real_q  <= ram_rdata[2*DATA_W-1:DATA_W];
            imag_q  <= ram_rdata[DATA_W-1:0];
            valid_q <= 1'b1;
            last_q  <= rd_finishing;
            done_q  <= rd_finishing;
            if (rd_finishing) begin
               rd_bank      <= ~rd_bank;
               rd_cnt       <= '0;
               drain_active <= drain_chain;
            end else begin
               rd_cnt <= rd_cnt + 1'b1;
            end
         end else begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            if (drain_start) begin
               drain_active <= 1'b1;
               rd_cnt       <= '0;
            end
         end
      end
   end

   assign bus.real_out  = real_q;
   assign bus.imag_out  = imag_q;
   assign bus.valid_out = valid_q;
   assign bus.last_out  = last_q;
   assign bus.done      = done_q;
   assign bus.frame_err = frame_err_q;
   assign bus.bank_dbg  = {bank_state[1], bank_state[0]};

endmodule
